// File: rtl/stg_pkg.sv
// rtl/stg_pkg.sv - shared player/playfield definitions for the shooter game
//
// Purpose: player life-cycle state encoding, respawn coordinates, playfield
// limits and a small state classification helper.
package stg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIVE  = 3'd1,
    HIT    = 3'd2,
    INVULN = 3'd3,
    OVER   = 3'd4
  } state_e;

  // Position the player datapath reloads on a respawn pulse.
  localparam int RESPAWN_X = 192;
  localparam int RESPAWN_Y = 400;

  // Playfield extent in pixels.
  localparam int MAX_X = 384;
  localparam int MAX_Y = 448;

  // States whose duration is measured in frames by the main countdown.
  function automatic logic is_timed_state(state_e s);
    return (s == HIT) || (s == INVULN);
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// rtl/frame_countdown.sv - 8-bit loadable frame down-counter
//
// Purpose: counts frame ticks down from a loaded value and flags the tick
// that brings the count to zero.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset (count -> 0)
//   load      in   load load_val this cycle (wins over tick)
//   load_val  in   8-bit value to load
//   tick      in   decrement request
//   zero      out  count is currently 0
//   done      out  one-cycle pulse on the tick that takes the count from 1 to 0
module frame_countdown (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  output logic       zero,
  output logic       done
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != 8'd0)) begin
      // A tick at zero holds the count rather than wrapping to 255.
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 8'd0);
  // done ignores load so a caller may reload in reaction to done without
  // creating a combinational loop.
  assign done = tick && (cnt_q == 8'd1);

endmodule

// File: rtl/player_life_ctrl.sv
// rtl/player_life_ctrl.sv - player life-cycle sequencer
//
// Purpose: sequences start, alive, hit animation, respawn, invulnerability
// blink and game over for the player sprite. All outputs are registered.
// Ports:
//   clk             in   system clock
//   reset           in   synchronous, active-high reset
//   frame_tick      in   one-cycle pulse per video frame
//   collision       in   player/bullet overlap this cycle
//   start           in   begins a game from IDLE or OVER
//   lives           out  remaining lives (3 bits)
//   hit_show        out  player datapath selects the hit sprite
//   player_visible  out  0 suppresses the player sprite
//   move_enable     out  player accepts movement controls
//   respawn         out  one-cycle pulse; player reloads its start position
//   game_over       out  high while in OVER
module player_life_ctrl
  import stg_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int HIT_FRAMES    = 30,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic       start,
  output logic [2:0] lives,
  output logic       hit_show,
  output logic       player_visible,
  output logic       move_enable,
  output logic       respawn,
  output logic       game_over
);

  localparam logic [2:0] LIVES_L  = 3'(LIVES_INIT);
  localparam logic [7:0] HIT_L    = 8'(HIT_FRAMES);
  localparam logic [7:0] INVULN_L = 8'(INVULN_FRAMES);
  localparam logic [7:0] BLINK_L  = 8'(BLINK_FRAMES);

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic       hit_show_q, hit_show_d;
  logic       visible_q, visible_d;
  logic       move_q, move_d;
  logic       respawn_q, respawn_d;
  logic       game_over_q, game_over_d;

  logic       cnt_load, cnt_tick, cnt_zero, cnt_done;
  logic [7:0] cnt_val;
  logic       blink_load, blink_tick, blink_zero, blink_done;

  // Frame ticks only count while a timed state is active; in ALIVE a tick
  // coinciding with a collision is therefore never consumed.
  assign cnt_tick   = frame_tick && is_timed_state(state_q) && !cnt_zero;
  assign blink_tick = frame_tick && (state_q == INVULN) && !blink_zero;

  frame_countdown u_frame_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (cnt_tick),
    .zero     (cnt_zero),
    .done     (cnt_done)
  );

  // Blink divider: reloads every BLINK_FRAMES ticks, each expiry flips visibility.
  frame_countdown u_blink_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (blink_load),
    .load_val (BLINK_L),
    .tick     (blink_tick),
    .zero     (blink_zero),
    .done     (blink_done)
  );

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    cnt_load    = 1'b0;
    cnt_val     = HIT_L;
    blink_load  = 1'b0;
    respawn_d   = 1'b0;
    hit_show_d  = 1'b0;
    visible_d   = 1'b0;
    move_d      = 1'b0;
    game_over_d = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        // start outranks a simultaneous collision in OVER.
        if (start) begin
          lives_d   = LIVES_L;
          state_d   = ALIVE;
          respawn_d = 1'b1;
        end
      end
      ALIVE: begin
        if (collision) begin
          cnt_load = 1'b1;
          cnt_val  = HIT_L;
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            state_d = HIT;
          end else begin
            lives_d = 3'd0;
            state_d = OVER;
          end
        end
      end
      HIT: begin
        if (cnt_done) begin
          cnt_load   = 1'b1;
          cnt_val    = INVULN_L;
          blink_load = 1'b1;
          respawn_d  = 1'b1;
          state_d    = INVULN;
        end
      end
      INVULN: begin
        if (blink_done) begin
          blink_load = 1'b1;
        end
        if (cnt_done) begin
          state_d = ALIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are derived from the next state so they land with it.
    unique case (state_d)
      ALIVE: begin
        visible_d = 1'b1;
        move_d    = 1'b1;
      end
      HIT: begin
        hit_show_d = 1'b1;
        visible_d  = 1'b1;
      end
      INVULN: begin
        move_d = 1'b1;
        if (state_q != INVULN) begin
          visible_d = 1'b1;
        end else if (blink_done) begin
          visible_d = !visible_q;
        end else begin
          visible_d = visible_q;
        end
      end
      OVER: begin
        game_over_d = 1'b1;
        hit_show_d  = 1'b1;
        visible_d   = 1'b1;
      end
      default: begin
        visible_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lives_q     <= LIVES_L;
      hit_show_q  <= 1'b0;
      visible_q   <= 1'b0;
      move_q      <= 1'b0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      hit_show_q  <= hit_show_d;
      visible_q   <= visible_d;
      move_q      <= move_d;
      respawn_q   <= respawn_d;
      game_over_q <= game_over_d;
    end
  end

  assign lives          = lives_q;
  assign hit_show       = hit_show_q;
  assign player_visible = visible_q;
  assign move_enable    = move_q;
  assign respawn        = respawn_q;
  assign game_over      = game_over_q;

endmodule
